mem_dump_unit: RTL and testbench

- Reads a contiguous window of the CPU data memory after a program run and streams each word out over a valid/ready interface.
- It is the read-back counterpart to program loading into `data_mem`: loading writes words in, this block reads results out.
- It sits beside the `RISC_V` core on the data-memory read port, which is muxed by `busy`, and feeds a host or debug sink.

---
 rtl/mem_dump_unit.sv | 103 ++++++++++
 tb/tb_mem_dump_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_unit.sv
// Streams a contiguous window of data memory out over a valid/ready port.
// One word per RD -> WT -> SEND pass; the read port is owned while busy.
module mem_dump_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, RD, WT, SEND, FIN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_re     = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (word_count != '0) ? RD : FIN;
      end
      RD: begin
        mem_re     = 1'b1;
        busy       = 1'b1;
        state_next = WT;
      end
      WT: begin
        busy       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_next = (remain > CNT_W'(1)) ? RD : FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // mem_addr is only reloaded on entry to RD so it keeps its last value elsewhere
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      remain   <= '0;
      mem_addr <= '0;
      out_data <= '0;
      out_addr <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && word_count != '0) begin
            addr     <= base_addr;
            remain   <= word_count;
            mem_addr <= base_addr;
          end
        end
        WT: begin
          out_data <= mem_rdata;
          out_addr <= addr;
          out_last <= (remain == CNT_W'(1));
        end
        SEND: begin
          if (out_ready) begin
            remain <= remain - CNT_W'(1);
            addr   <= addr + ADDR_W'(1);
            if (remain > CNT_W'(1)) mem_addr <= addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_unit.sv
// Randomized bench for mem_dump_unit: a synchronous memory model feeds the DUT and
// every dump is compared with the word list computed directly from base and count.
module tb_mem_dump_unit;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 11;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [DEPTH];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_mode = 0;
  int pat_idx = 0;

  logic [ADDR_W+DATA_W:0] got_q [$];
  int hs_count, mre_count, done_count, valid_seen;
  int first_valid_cyc, last_hs_cyc, done_cyc, start_cyc;
  bit prev_stall;
  logic [ADDR_W+DATA_W:0] prev_word;

  mem_dump_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Sink ready: 0 always 1, 1 pattern 1,0,0,1, 2 random, 3 held low
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      pat_idx++;
    end
  end

  // Observe transfers, reads and done pulses; verify held outputs during stalls
  initial begin
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (mem_re) mre_count++;
        if (done) begin
          done_count++;
          done_cyc = cyc;
        end
        if (out_valid && valid_seen == 0) first_valid_cyc = cyc;
        if (out_valid) begin
          valid_seen++;
          checkOutput("busy_in_send", busy, 1);
        end
        if (prev_stall)
          checkOutput("stall_hold", {out_valid, out_last, out_addr, out_data}, {1'b1, prev_word});
        if (out_valid && out_ready) begin
          got_q.push_back({out_last, out_addr, out_data});
          hs_count++;
          last_hs_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_last, out_addr, out_data};
      end
    end
  end

  task automatic clearStats();
    got_q.delete();
    hs_count = 0; mre_count = 0; done_count = 0; valid_seen = 0;
    first_valid_cyc = 0; last_hs_cyc = 0; done_cyc = 0;
  endtask

  task automatic applyStimulus(input int base, input int cnt, input int mode, input bit poke);
    int a;
    logic [ADDR_W+DATA_W:0] expw;
    clearStats();
    ready_mode = mode;
    @(posedge clk); #1;
    start = 1'b1; base_addr = ADDR_W'(base); word_count = CNT_W'(cnt); start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ADDR_W'($urandom); word_count = CNT_W'($urandom);
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1; base_addr = '0; word_count = CNT_W'(7);
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < cnt * 40 + 20 && done_count == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_once", done_count, 1);
    checkOutput("words_out", got_q.size(), cnt);
    checkOutput("mem_reads", mre_count, cnt);
    for (int i = 0; i < cnt && i < got_q.size(); i++) begin
      a = (base + i) % DEPTH;
      expw = {(i == cnt - 1), ADDR_W'(a), mem[a]};
      checkOutput($sformatf("word%0d", i), got_q[i], expw);
    end
    if (cnt > 0) begin
      checkOutput("first_latency", first_valid_cyc - start_cyc, 3);
      checkOutput("done_after_last", done_cyc - last_hs_cyc, 1);
    end else begin
      checkOutput("zero_no_valid", valid_seen, 0);
      checkOutput("zero_done_time", done_cyc - start_cyc, 1);
    end
  endtask

  task automatic resetMidDump();
    bit seen;
    clearStats();
    ready_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = ADDR_W'(100); word_count = CNT_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 40 && hs_count == 0; i++) begin
      @(negedge clk); #1;
    end
    ready_mode = 3;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (out_valid && hs_count == 1) seen = 1'b1;
    end
    checkOutput("reached_word2", seen, 1);
    rst = 1'b0;
    #1;
    checkOutput("rst_drops", {out_valid, busy, mem_re, done}, 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_no_done", done_count, 0);
    checkOutput("rst_partial", hs_count, 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i * 4 + 'h100);
    clearStats();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {mem_re, out_valid, busy, done, out_last, out_addr, out_data, mem_addr}, '0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(5, 3, 0, 1'b0);
    applyStimulus(5, 3, 1, 1'b0);
    applyStimulus('h3FE, 4, 0, 1'b0);
    applyStimulus(9, 0, 0, 1'b0);
    resetMidDump();
    applyStimulus(100, 5, 0, 1'b0);
    applyStimulus(20, 4, 0, 1'b1);

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int t = 0; t < 10; t++)
      applyStimulus($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), 2, 1'b0);
    applyStimulus($urandom_range(0, DEPTH - 1), DEPTH + 6, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
